// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I-cache / D-cache arbiter for a shared memory line port
//
// Purpose: grants the physical-memory line port to one cache at a time. The
// granted address and write line are registered. The read line is captured
// into line_buf. A one-cycle resp pulse returns to the requester. When both
// caches contend, grants alternate between them.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   icache_read/address              I-cache line read request
//   icache_rdata/resp                I-cache returned line and completion pulse
//   dcache_read/write/address/wdata  D-cache line read or write-back request
//   dcache_rdata/resp                D-cache returned line and completion pulse
//   mem_read/write/address/wdata     registered request to memory
//   mem_rdata/resp                   memory read line and completion

module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t                  state;
  logic                    prio_d;    // 1: D wins the next contended grant
  logic [LINE_WIDTH-1:0]   line_buf;

  logic i_pend;
  logic d_pend;
  logic grant_d;

  assign i_pend  = icache_read;
  assign d_pend  = dcache_read | dcache_write;
  // D wins when it is the only requester, or when both contend and prio favours D.
  assign grant_d = d_pend & (~i_pend | prio_d);

  assign icache_rdata = line_buf;
  assign dcache_rdata = line_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prio_d      <= 1'b1;
      line_buf    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      icache_resp <= 1'b0;
      dcache_resp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= SERVE_D;
            mem_address <= dcache_address;
            mem_wdata   <= dcache_wdata;
            // A write-back takes precedence if both D strobes are high.
            mem_write   <= dcache_write;
            mem_read    <= ~dcache_write;
          end else if (i_pend) begin
            state       <= SERVE_I;
            mem_address <= icache_address;
            mem_wdata   <= '0;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            line_buf  <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // The side just served yields the next contended grant.
            prio_d    <= (state == SERVE_I);
            if (state == SERVE_I) begin
              state       <= RESP_I;
              icache_resp <= 1'b1;
            end else begin
              state       <= RESP_D;
              dcache_resp <= 1'b1;
            end
          end
        end
        RESP_I, RESP_D: begin
          icache_resp <= 1'b0;
          dcache_resp <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          icache_resp <= 1'b0;
          dcache_resp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter

module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  int total = 0;
  int bad   = 0;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("rw_excl", LW'(mem_read & mem_write), LW'(0));
      check("d_rd_wr_illegal", LW'(dcache_read & dcache_write), LW'(0));
    end
  end

  // Waits for the memory request, checks it, answers after lat cycles and
  // checks the one-cycle response. chg_addr (if nonzero) perturbs the I address
  // mid-serve to show the latched address holds.
  task automatic txn(input string tag, input bit exp_d, input logic [AW-1:0] exp_addr,
                     input bit exp_wr, input logic [LW-1:0] exp_wdata, input int lat,
                     input logic [LW-1:0] line, input bit drop, input logic [AW-1:0] chg_addr);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, LW'(n < 20), LW'(1));
    check({tag, "_addr"}, LW'(mem_address), LW'(exp_addr));
    check({tag, "_mwrite"}, LW'(mem_write), LW'(exp_wr));
    check({tag, "_mread"}, LW'(mem_read), LW'(!exp_wr));
    if (exp_wr) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    if (chg_addr != '0) icache_address = chg_addr;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check({tag, "_addr_hold"}, LW'(mem_address), LW'(exp_addr));
      check({tag, "_req_hold"}, LW'(mem_read | mem_write), LW'(1));
    end
    mem_rdata = line;
    mem_resp  = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = {8{32'h0BAD_F00D}};
    check({tag, "_iresp"}, LW'(icache_resp), LW'(!exp_d));
    check({tag, "_dresp"}, LW'(dcache_resp), LW'(exp_d));
    check({tag, "_mem_idle"}, LW'(mem_read | mem_write), LW'(0));
    if (!exp_wr) check({tag, "_rdata"}, exp_d ? dcache_rdata : icache_rdata, line);
    if (drop) begin
      if (exp_d) begin
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
      end else begin
        icache_read = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_resp_pulse"}, LW'(icache_resp | dcache_resp), LW'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] la5;
    logic [LW-1:0] lbeef;
    int n;
    la5   = {32{8'hA5}};
    lbeef = {8{32'hDEAD_BEEF}};

    repeat (2) @(negedge clk);
    check("rst_mread", LW'(mem_read), LW'(0));
    check("rst_mwrite", LW'(mem_write), LW'(0));
    check("rst_iresp", LW'(icache_resp), LW'(0));
    check("rst_dresp", LW'(dcache_resp), LW'(0));
    check("rst_addr", LW'(mem_address), LW'(0));
    check("rst_wdata", mem_wdata, LW'(0));
    check("rst_rdata", icache_rdata, LW'(0));
    rst = 1'b0;
    @(negedge clk);

    // I-only read
    icache_read = 1'b1; icache_address = 32'h0000_1000;
    txn("i_only", 1'b0, 32'h0000_1000, 1'b0, '0, 2, la5, 1'b1, '0);

    // D write-back
    dcache_write = 1'b1; dcache_address = 32'h8000_0040; dcache_wdata = lbeef;
    txn("d_wb", 1'b1, 32'h8000_0040, 1'b1, lbeef, 1, {LW{1'b1}}, 1'b1, '0);

    // Simultaneous right after reset: D first, then I
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    icache_read = 1'b1; icache_address = 32'h100;
    dcache_read = 1'b1; dcache_address = 32'h200;
    txn("sim_d", 1'b1, 32'h200, 1'b0, '0, 1, {8{32'h1111_2222}}, 1'b1, '0);
    txn("sim_i", 1'b0, 32'h100, 1'b0, '0, 2, {8{32'h3333_4444}}, 1'b1, '0);

    // Fairness: both hold requests for 6 transactions; last served was I so D leads
    icache_read = 1'b1; icache_address = 32'h3000;
    dcache_read = 1'b1; dcache_address = 32'h2000;
    txn("fair0_d", 1'b1, 32'h2000, 1'b0, '0, 1, {LW{1'b0}} | 256'h10, 1'b0, '0);
    txn("fair1_i", 1'b0, 32'h3000, 1'b0, '0, 2, {LW{1'b0}} | 256'h11, 1'b0, '0);
    txn("fair2_d", 1'b1, 32'h2000, 1'b0, '0, 3, {LW{1'b0}} | 256'h12, 1'b0, '0);
    txn("fair3_i", 1'b0, 32'h3000, 1'b0, '0, 1, {LW{1'b0}} | 256'h13, 1'b0, '0);
    txn("fair4_d", 1'b1, 32'h2000, 1'b0, '0, 2, {LW{1'b0}} | 256'h14, 1'b1, '0);
    txn("fair5_i", 1'b0, 32'h3000, 1'b0, '0, 1, {LW{1'b0}} | 256'h15, 1'b1, '0);

    // Address stability: I address changes during SERVE
    icache_read = 1'b1; icache_address = 32'h300;
    txn("addr_hold", 1'b0, 32'h300, 1'b0, '0, 3, la5, 1'b1, 32'h400);

    // Reset in the middle of SERVE_D
    dcache_read = 1'b1; dcache_address = 32'h500;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_req_seen", LW'(mem_read), LW'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mread", LW'(mem_read), LW'(0));
    check("mid_rst_dresp", LW'(dcache_resp), LW'(0));
    check("mid_rst_addr", LW'(mem_address), LW'(0));
    dcache_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", LW'({mem_read, mem_write, icache_resp, dcache_resp}), LW'(0));
    end
    icache_read = 1'b1; icache_address = 32'h600;
    txn("post_rst_i", 1'b0, 32'h600, 1'b0, '0, 2, {8{32'hCAFE_F00D}}, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
